// File: rtl/led_pattern_driver.sv
// led_pattern_driver: prescaled BOUNCE/ROTATE/FILL/BLINK LED patterns; in iCLK iRST iMODE iSPEED iPAUSE, out registered oLED oTICK
module led_pattern_driver #(
  parameter int WIDTH    = 8,
  parameter int DIV_BITS = 21,
  parameter int BAR_LEN  = 3
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [1:0]       iMODE,
  input  logic [1:0]       iSPEED,
  input  logic             iPAUSE,
  output logic [WIDTH-1:0] oLED,
  output logic             oTICK
);
  typedef enum logic [1:0] {BOUNCE, ROTATE, FILL, BLINK} mode_t;
  localparam logic [WIDTH-1:0] BAR = {{(WIDTH-BAR_LEN){1'b0}}, {BAR_LEN{1'b1}}};
  localparam logic [DIV_BITS-1:0] ONE = 1;
  mode_t mode_q, mode_in;
  logic [DIV_BITS-1:0] cnt, mask;
  logic [WIDTH-1:0] init, nxt;
  logic dir, step, go_right, nxt_dir;
  always_comb begin
    mode_in  = mode_t'(iMODE);
    mask     = {DIV_BITS{1'b1}} >> iSPEED;
    step     = &(cnt | ~mask);
    init     = (mode_in == BOUNCE || mode_in == ROTATE) ? BAR : '0;
    go_right = dir ? !oLED[0] : oLED[WIDTH-1];
    nxt_dir  = mode_q == BOUNCE ? go_right : dir;
    nxt      = mode_q == BOUNCE ? (go_right ? oLED >> 1 : oLED << 1) :
               mode_q == ROTATE ? {oLED[WIDTH-2:0], oLED[WIDTH-1]} :
               mode_q == FILL   ? (&oLED ? '0 : {oLED[WIDTH-2:0], 1'b1}) : ~oLED;
  end
  always_ff @(posedge iCLK) begin
    mode_q <= mode_in;
    if (iRST || mode_in != mode_q) begin
      cnt   <= '0;
      dir   <= 1'b0;
      oTICK <= 1'b0;
      oLED  <= init;
    end else if (iPAUSE) begin
      oTICK <= 1'b0;
    end else begin
      cnt   <= cnt + ONE;
      oTICK <= step;
      if (step) begin
        oLED <= nxt;
        dir  <= nxt_dir;
      end
    end
  end
endmodule

// File: tb/tb_led_pattern_driver.sv
// tb_led_pattern_driver: scoreboard bench comparing led_pattern_driver against a step-index pattern model
module tb_led_pattern_driver;
  logic iCLK = 1'b0, iRST = 1'b1, iPAUSE = 1'b0;
  logic [1:0] iMODE = 2'd0, iSPEED = 2'd0;
  logic [7:0] oLED;
  logic oTICK;
  led_pattern_driver #(.WIDTH(8), .DIV_BITS(4), .BAR_LEN(3)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMODE(iMODE), .iSPEED(iSPEED),
    .iPAUSE(iPAUSE), .oLED(oLED), .oTICK(oTICK)
  );
  always #5 iCLK = ~iCLK;
  logic [8:0] exp_q[$];
  logic [7:0] tick_log[$];
  int n_cmp = 0, n_bad = 0, phase = 0;
  int mc = 0, mk = 0, mm = 0;
  logic mt = 1'b0;
  function automatic logic [7:0] pat(int md, int k);
    logic [15:0] b;
    int p, o;
    b = 16'h0007;
    case (md)
      0: begin
        p = k % 10;
        o = (p <= 5) ? p : 10 - p;
        b = b << o;
        return b[7:0];
      end
      1: begin
        b = b << (k % 8);
        return b[7:0] | b[15:8];
      end
      2: begin
        b = (16'd1 << (k % 9)) - 16'd1;
        return b[7:0];
      end
      default: return (k % 2 == 1) ? 8'hFF : 8'h00;
    endcase
  endfunction
  task automatic cyc(input logic r, input logic [1:0] m, input logic [1:0] s, input logic p);
    int per;
    @(negedge iCLK);
    iRST = r; iMODE = m; iSPEED = s; iPAUSE = p;
    if (r) begin
      mc = 0; mk = 0; mm = int'(m); mt = 1'b0;
    end else if (int'(m) != mm) begin
      mm = int'(m); mc = 0; mk = 0; mt = 1'b0;
    end else if (p) begin
      mt = 1'b0;
    end else begin
      per = 1 << (4 - int'(s));
      mt = (mc % per) == per - 1;
      mc = (mc + 1) % 16;
      if (mt) mk++;
    end
    exp_q.push_back({pat(mm, mk), mt});
  endtask
  initial forever begin
    logic [8:0] e;
    @(posedge iCLK);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({oLED, oTICK} !== e) begin
        n_bad++;
        $display("FAIL cycle t=%0t got led=%h tick=%b expected led=%h tick=%b", $time, oLED, oTICK, e[8:1], e[0]);
      end
      if (phase == 1 && oTICK === 1'b1) tick_log.push_back(oLED);
    end
  end
  initial begin
    logic [7:0] bounce_ref [12];
    bounce_ref = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E, 8'h1C};
    repeat (2) cyc(1, 0, 0, 0);
    phase = 1;
    repeat (192) cyc(0, 0, 0, 0);
    @(posedge iCLK);
    #2 phase = 0;
    repeat (40) cyc(0, 2, 2, 0);
    repeat (140) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 200 && pat(mm, mk) != 8'hE0; i++) cyc(0, 0, 0, 0);
    repeat (40) cyc(0, 0, 0, 1);
    repeat (20) cyc(0, 0, 0, 0);
    for (int i = 0; i < 16 && mc != 15; i++) cyc(0, 0, 0, 0);
    repeat (40) cyc(0, 3, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 300 && !(mk % 10 >= 6 && mc == 15); i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (20) cyc(0, 0, 0, 0);
    begin
      logic [1:0] rm, rs;
      rm = 2'd0; rs = 2'd2;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(39) == 0) rm = 2'($urandom_range(3));
        if ($urandom_range(19) == 0) rs = 2'($urandom_range(3));
        cyc($urandom_range(59) == 0, rm, rs, $urandom_range(7) == 0);
      end
    end
    repeat (2) @(posedge iCLK);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (i >= tick_log.size()) begin
        n_bad++;
        $display("FAIL bounce_seq[%0d] got no tick expected %h", i, bounce_ref[i]);
      end else if (tick_log[i] !== bounce_ref[i]) begin
        n_bad++;
        $display("FAIL bounce_seq[%0d] got %h expected %h", i, tick_log[i], bounce_ref[i]);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
